// File: rtl/vtx_trace_pkg.sv
// Shared layout constants for vtx_trace_buffer entries.
// An entry holds the retire fields, the status flags, NTXN txn slots and the
// slot count in the most significant bits.
package vtx_trace_pkg;

    // Txn slot: {rdata, wdata, addr, ben, error, wen, cen}
    localparam int unsigned TXN_W    = 103;
    localparam int unsigned SL_CEN   = 0;
    localparam int unsigned SL_WEN   = 1;
    localparam int unsigned SL_ERR   = 2;
    localparam int unsigned SL_BEN   = 3;
    localparam int unsigned SL_ADDR  = 7;
    localparam int unsigned SL_WDATA = 39;
    localparam int unsigned SL_RDATA = 71;

    // Entry fields below the slot array
    localparam int unsigned OFF_WEN    = 0;
    localparam int unsigned OFF_WADDR  = 1;
    localparam int unsigned OFF_WDATA  = 6;
    localparam int unsigned OFF_RESULT = 38;
    localparam int unsigned OFF_RS1    = 41;
    localparam int unsigned OFF_ENC    = 73;
    localparam int unsigned OFF_INC    = 105;
    localparam int unsigned OFF_OVF    = 106;
    localparam int unsigned OFF_SLOTS  = 107;

    // Count field sits above the slots so its width can follow NTXN exactly
    function automatic int unsigned off_cnt(input int unsigned ntxn);
        return OFF_SLOTS + ntxn * TXN_W;
    endfunction

    function automatic int unsigned entry_width(input int unsigned ntxn);
        return off_cnt(ntxn) + $clog2(ntxn + 1);
    endfunction

endpackage

// File: rtl/vtx_trace_fifo.sv
// Generic synchronous FIFO; head word is read straight from the storage
// registers so the consumer sees registered data.
module vtx_trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot being written
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    // Pointer registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_ok);
            rd_ptr_q <= rd_ptr_q + PW'(pop_ok);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (resetn && push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/vtx_trace_buffer.sv
// Collects the memory transactions of each instruction, packs them with the
// retire fields into one entry and queues entries for the checkers.
module vtx_trace_buffer
    import vtx_trace_pkg::*;
#(
    parameter int unsigned NTXN  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         vtx_clk,
    input  logic                         vtx_resetn,
    input  logic                         mem_req,
    input  logic                         mem_gnt,
    input  logic                         mem_wen,
    input  logic [31:0]                  mem_addr,
    input  logic [31:0]                  mem_wdata,
    input  logic [3:0]                   mem_ben,
    input  logic                         mem_rsp,
    input  logic [31:0]                  mem_rdata,
    input  logic                         mem_error,
    input  logic                         trs_valid,
    input  logic [31:0]                  trs_enc,
    input  logic [31:0]                  trs_rs1,
    input  logic [2:0]                   trs_result,
    input  logic [31:0]                  trs_wdata,
    input  logic [4:0]                   trs_waddr,
    input  logic                         trs_wen,
    output logic                         vtx_valid,
    input  logic                         vtx_ready,
    output logic [31:0]                  vtx_instr_enc,
    output logic [31:0]                  vtx_instr_rs1,
    output logic [2:0]                   vtx_instr_result,
    output logic [31:0]                  vtx_instr_wdata,
    output logic [4:0]                   vtx_instr_waddr,
    output logic                         vtx_instr_wen,
    output logic [NTXN-1:0]              vtx_mem_cen,
    output logic [NTXN-1:0]              vtx_mem_wen,
    output logic [NTXN-1:0]              vtx_mem_error,
    output logic [32*NTXN-1:0]           vtx_mem_addr,
    output logic [32*NTXN-1:0]           vtx_mem_wdata,
    output logic [32*NTXN-1:0]           vtx_mem_rdata,
    output logic [4*NTXN-1:0]            vtx_mem_ben,
    output logic [$clog2(NTXN+1)-1:0]    vtx_txn_count,
    output logic                         vtx_txn_ovf,
    output logic                         vtx_incomplete,
    output logic [15:0]                  vtx_lost
);

    localparam int unsigned   CW    = $clog2(NTXN + 1);
    localparam int unsigned   EW    = entry_width(NTXN);
    localparam int unsigned   OCNT  = off_cnt(NTXN);
    localparam logic [CW-1:0] SLOTS = CW'(NTXN);

    logic [CW-1:0]    req_ptr_q, req_ptr_d, rsp_ptr_q, rsp_ptr_d, rsp_ptr_upd, wr_idx;
    logic             ovf_q, ovf_d;
    logic [TXN_W-1:0] slot_q [NTXN];
    logic [TXN_W-1:0] slot_d [NTXN];
    logic [TXN_W-1:0] slot_rsp [NTXN];
    logic             req_acc, rsp_hit, pop, drop;
    logic [EW-1:0]    entry, fifo_rdata, head;
    logic             fifo_full, fifo_empty;
    logic [15:0]      lost_q;

    assign req_acc = mem_req && mem_gnt;
    assign rsp_hit = mem_rsp && (rsp_ptr_q < req_ptr_q);

    // Fold this cycle's response into the slots; it belongs to the current instruction
    always_comb begin
        slot_rsp    = slot_q;
        rsp_ptr_upd = rsp_ptr_q + CW'(rsp_hit);
        for (int unsigned i = 0; i < NTXN; i++) begin
            if (rsp_hit && rsp_ptr_q == CW'(i)) begin
                slot_rsp[i][SL_RDATA +: 32] = mem_rdata;
                slot_rsp[i][SL_ERR]         = mem_error;
            end
        end
    end

    // Accumulator next state: retire clears, then a request lands in the next free slot
    always_comb begin
        slot_d    = slot_rsp;
        req_ptr_d = req_ptr_q;
        rsp_ptr_d = rsp_ptr_upd;
        ovf_d     = ovf_q;
        wr_idx    = trs_valid ? '0 : req_ptr_q;
        if (trs_valid) begin
            for (int unsigned i = 0; i < NTXN; i++) begin
                slot_d[i] = '0;
            end
            req_ptr_d = '0;
            rsp_ptr_d = '0;
            ovf_d     = 1'b0;
        end
        if (req_acc) begin
            if (wr_idx < SLOTS) begin
                for (int unsigned i = 0; i < NTXN; i++) begin
                    if (wr_idx == CW'(i)) begin
                        slot_d[i][SL_CEN]         = 1'b1;
                        slot_d[i][SL_WEN]         = mem_wen;
                        slot_d[i][SL_BEN +: 4]    = mem_ben;
                        slot_d[i][SL_ADDR +: 32]  = mem_addr;
                        slot_d[i][SL_WDATA +: 32] = mem_wdata;
                    end
                end
                req_ptr_d = wr_idx + CW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Accumulator registers
    always_ff @(posedge vtx_clk) begin
        if (!vtx_resetn) begin
            req_ptr_q <= '0;
            rsp_ptr_q <= '0;
            ovf_q     <= 1'b0;
            for (int unsigned i = 0; i < NTXN; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            req_ptr_q <= req_ptr_d;
            rsp_ptr_q <= rsp_ptr_d;
            ovf_q     <= ovf_d;
            slot_q    <= slot_d;
        end
    end

    // Pack the entry for the retiring instruction
    always_comb begin
        entry                       = '0;
        entry[OFF_WEN]              = trs_wen;
        entry[OFF_WADDR +: 5]       = trs_waddr;
        entry[OFF_WDATA +: 32]      = trs_wdata;
        entry[OFF_RESULT +: 3]      = trs_result;
        entry[OFF_RS1 +: 32]        = trs_rs1;
        entry[OFF_ENC +: 32]        = trs_enc;
        entry[OFF_INC]              = (rsp_ptr_upd != req_ptr_q);
        entry[OFF_OVF]              = ovf_q;
        entry[OCNT +: CW]           = req_ptr_q;
        for (int unsigned i = 0; i < NTXN; i++) begin
            entry[OFF_SLOTS + i*TXN_W +: TXN_W] = slot_rsp[i];
        end
    end

    assign pop  = vtx_valid && vtx_ready;
    assign drop = trs_valid && fifo_full && !pop;

    vtx_trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (vtx_clk),
        .resetn (vtx_resetn),
        .push   (trs_valid),
        .wdata  (entry),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Saturating count of entries dropped on a full queue
    always_ff @(posedge vtx_clk) begin
        if (!vtx_resetn) begin
            lost_q <= '0;
        end else if (drop && lost_q != 16'hFFFF) begin
            lost_q <= lost_q + 16'd1;
        end
    end

    // Stale storage must not leak onto the outputs while the queue is empty
    assign head      = fifo_empty ? '0 : fifo_rdata;
    assign vtx_valid = !fifo_empty;
    assign vtx_lost  = lost_q;

    assign vtx_instr_enc    = head[OFF_ENC +: 32];
    assign vtx_instr_rs1    = head[OFF_RS1 +: 32];
    assign vtx_instr_result = head[OFF_RESULT +: 3];
    assign vtx_instr_wdata  = head[OFF_WDATA +: 32];
    assign vtx_instr_waddr  = head[OFF_WADDR +: 5];
    assign vtx_instr_wen    = head[OFF_WEN];
    assign vtx_incomplete   = head[OFF_INC];
    assign vtx_txn_ovf      = head[OFF_OVF];
    assign vtx_txn_count    = head[OCNT +: CW];

    for (genvar g = 0; g < NTXN; g++) begin : g_slot
        localparam int unsigned B = OFF_SLOTS + g * TXN_W;
        assign vtx_mem_cen[g]            = head[B + SL_CEN];
        assign vtx_mem_wen[g]            = head[B + SL_WEN];
        assign vtx_mem_error[g]          = head[B + SL_ERR];
        assign vtx_mem_ben[g*4 +: 4]     = head[B + SL_BEN +: 4];
        assign vtx_mem_addr[g*32 +: 32]  = head[B + SL_ADDR +: 32];
        assign vtx_mem_wdata[g*32 +: 32] = head[B + SL_WDATA +: 32];
        assign vtx_mem_rdata[g*32 +: 32] = head[B + SL_RDATA +: 32];
    end

endmodule

// File: doc/vtx_trace_buffer.md
# vtx_trace_buffer

Parametrised capture-and-queue stage between the core's trace outputs and the formal/simulation checker modules. Accumulates up to `NTXN` memory transactions per instruction, packs them with the retired-instruction fields into one trace entry, and queues entries in a `DEPTH`-deep FIFO. Entries are presented to checkers under a valid/ready handshake. This generalises the fixed four-transaction checker interface with a configurable slot count, buffering, overflow detection and loss accounting.

## Interface
- `NTXN`, 4, memory-transaction slots per entry (1..8)
- `DEPTH`, 4, FIFO entries (power of two, >=2)
- `vtx_clk` in 1: sole clock
- `vtx_resetn` in 1: synchronous, active-low reset
- `mem_req` in 1, `mem_gnt` in 1: request accepted when both high
- `mem_wen` in 1, `mem_addr` in 32, `mem_wdata` in 32, `mem_ben` in 4: request fields
- `mem_rsp` in 1, `mem_rdata` in 32, `mem_error` in 1: in-order response
- `trs_valid` in 1: instruction retires this cycle
- `trs_enc` in 32, `trs_rs1` in 32, `trs_result` in 3, `trs_wdata` in 32, `trs_waddr` in 5, `trs_wen` in 1: retire fields
- `vtx_valid` out 1, `vtx_ready` in 1: output handshake
- `vtx_instr_enc/rs1/result/wdata/waddr/wen` out 32/32/3/32/5/1: registered copies of the retire fields
- `vtx_mem_cen/wen/error` out NTXN each; `vtx_mem_addr/wdata/rdata` out 32*NTXN each; `vtx_mem_ben` out 4*NTXN: slot i at bits [i*W +: W]
- `vtx_txn_count` out clog2(NTXN+1): number of valid slots
- `vtx_txn_ovf` out 1: more than NTXN requests were seen; extra requests are dropped
- `vtx_incomplete` out 1: retire occurred while responses were outstanding
- `vtx_lost` out 16: saturating count of entries dropped on FIFO full

## Operation
- Accumulator: `req_ptr` and `rsp_ptr`, each 0..NTXN.
  - An accepted request with `req_ptr<NTXN` writes slot[req_ptr] (cen=1, wen, addr, wdata, ben) and increments `req_ptr`.
  - An accepted request with `req_ptr==NTXN` sets `ovf` and writes nothing.
  - `mem_rsp` with `rsp_ptr<req_ptr` writes rdata/error into slot[rsp_ptr] and increments `rsp_ptr`.
  - `mem_rsp` with `rsp_ptr>=req_ptr` is ignored.
- Retire (`trs_valid`):
  - Build the entry from the retire fields, the slots, count=`req_ptr`, ovf, and incomplete=(`rsp_ptr`!=`req_ptr` after counting this cycle's response).
  - Push the entry. Clear the accumulator: pointers=0, all slot cen=0, ovf=0.
- Ownership on the retire cycle:
  - A response in that cycle belongs to the retiring instruction.
  - A request in that cycle belongs to the next instruction and lands in slot 0.
- FIFO full at push: the entry is discarded and `vtx_lost` increments (saturates at 0xFFFF). The core is never stalled.
- Pop on `vtx_valid && vtx_ready`. Push and pop in the same cycle while full: the pop frees space, so the push succeeds.
- Unused slots in an output entry read as zero.

## Timing
- Retire in cycle N with an empty FIFO: `vtx_valid` high in N+1 with that entry. Outputs are registered FIFO head only.
- `vtx_valid` stays high and the outputs stay stable until the cycle after `vtx_ready` is sampled high.
- Throughput is one entry per cycle.
- Reset (`vtx_resetn`=0 at a `vtx_clk` edge), including mid-instruction:
  - Accumulator cleared; FIFO emptied; `vtx_lost`=0.
  - All outputs 0, including `vtx_valid`.
  - A retire in the reset cycle is discarded.

## Structure
- Package `vtx_trace_pkg`:
  - localparams for the txn slot width (103 bits) and the entry width as a function of NTXN.
  - Field offset constants used to pack and unpack entries.
- Sub-module `vtx_trace_fifo`: generic WIDTH/DEPTH synchronous FIFO with full/empty and registered head. The top level holds the accumulator, packing, and lost counter.

## Test plan
- One load, request addr 0x100, response rdata 0xDEADBEEF, then retire enc 0x0000A00B → entry has count=1, slot0 addr 0x100, rdata 0xDEADBEEF, ovf=0, incomplete=0.
- NTXN=4 with six requests and six responses, then retire → count=4, ovf=1, slots hold the first four addresses.
- Request and retire in the same cycle, response in the next cycle, second retire → first entry count=0; second entry count=1 with that request and response.
- `vtx_ready`=0 with DEPTH+3 retires → DEPTH entries kept, `vtx_lost`=3; then `vtx_ready`=1 → entries drain in order, one per cycle.
- Retire with two requests and one response → incomplete=1, slot1 rdata=0.
- Reset asserted after two requests → next entry count=0; `vtx_valid`=0 throughout reset.
